id_ex_latch: RTL
================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 SHALL have parameter WordSize, default 32, the datapath width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports id_valid in 1 and id_ready out 1, forming the decode-side handshake.
REQ-005 SHALL have ports id_pc, id_rs1_data, id_rs2_data and id_imm, each in WordSize, carrying the decoded operands.
REQ-006 SHALL have ports id_rs1_addr, id_rs2_addr and id_rd_addr, each in 5, carrying register indices.
REQ-007 SHALL have ports id_alu_mode in 6 (ALU opcode), id_use_imm in 1 (operand B is the immediate) and id_use_pc in 1 (operand A is the PC).
REQ-008 SHALL have port flush  in  1  to kill the held instruction.
REQ-009 SHALL have ports ex_valid out 1 and ex_ready in 1, forming the execute-side handshake.
REQ-010 SHALL have ports alu_a out WordSize, alu_b out WordSize and alu_mode out 6, driving the ALU operand and opcode inputs directly.
REQ-011 SHALL have ports ex_rd_addr out 5 (destination index) and ex_store_data out WordSize (forwarded rs2 value).
REQ-012 SHALL have forwarding ports fwd_mem_en in 1, fwd_mem_rd in 5 and fwd_mem_data in WordSize.
REQ-013 SHALL have forwarding ports fwd_wb_en in 1, fwd_wb_rd in 5 and fwd_wb_data in WordSize.

Function
REQ-014 SHALL drive id_ready = !ex_valid || ex_ready, combinationally; a capture occurs when id_valid && id_ready.
REQ-015 SHALL, on capture, register all id_* fields and set ex_valid=1 on the next edge; capture-to-output latency is 1 cycle.
REQ-016 SHALL clear ex_valid on an edge where ex_valid && ex_ready and no capture occurs.
REQ-017 SHALL hold all registered fields unchanged while ex_valid && !ex_ready, except for the refresh defined in REQ-021.
REQ-018 SHALL give flush priority over capture: flush=1 forces ex_valid=0 next edge; stored payload is don't-care, and id_ready behaves per REQ-014.
REQ-019 SHALL compute the forwarded rsN value as: fwd_mem_data if fwd_mem_en && fwd_mem_rd==rsN_addr && rsN_addr!=0; else fwd_wb_data if the same test passes for wb; else the stored rsN_data.
REQ-020 SHALL never forward for index 0; register x0 always reads its stored value.
REQ-021 SHALL, while holding (ex_valid && !ex_ready), write the forwarded rs1/rs2 values back into the stored operand registers each edge, so forwarded data survives the producer's retirement.
REQ-022 SHALL drive alu_a = id_use_pc ? pc : fwd(rs1) and alu_b = id_use_imm ? imm : fwd(rs2), both from registered selects, combinationally.
REQ-023 SHALL drive ex_store_data = fwd(rs2) regardless of id_use_imm.
REQ-024 SHALL pass alu_mode through unmodified; unknown codes are not checked.

Reset
REQ-025 SHALL, on rst, asynchronously set ex_valid=0, alu_mode=ADD (6'h00), ex_rd_addr=0 and all stored data, pc, imm and select registers to 0.
REQ-026 SHALL make id_ready=1 immediately while rst is asserted, and SHALL discard any in-flight instruction when rst is asserted mid-stall.

Structure
REQ-027 SHALL take the ALU opcode constants (ADD, SUB, XOR, OR, AND, LLS, LRS, ARS, SSLT, USLT) and an ex_ctrl struct (alu_mode, use_imm, use_pc, rd_addr) from a shared package, core_pkg.
REQ-028 SHALL implement the REQ-019 priority selector as one sub-module, fwd_sel, instantiated twice (rs1, rs2).

Verification
REQ-029 Capture check: capture rs1=5, rs2=7, mode=ADD, ex_ready=1 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_mode=0x00.
REQ-030 Forwarding priority check: held rs1_addr=3, with mem (rd=3, data=0xAA) and wb (rd=3, data=0xBB) both enabled -> alu_a=0xAA; mem disabled -> alu_a=0xBB.
REQ-031 Refresh check: stall with ex_ready=0 and a wb forward of rd=4, data=0x55 to rs2_addr=4 for 1 cycle, then wb disabled -> alu_b and ex_store_data stay 0x55.
REQ-032 x0 check: rs1_addr=0 with stored value 0 and mem forward rd=0, data=0xFF -> alu_a=0.
REQ-033 Flush check: flush=1 together with id_valid=1 and ex_ready=1 -> ex_valid=0 next cycle.
REQ-034 Reset check: assert rst mid-stall with ex_valid=1 -> ex_valid=0, alu_mode=0x00 and id_ready=1 without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ALU opcode constants, the execute-stage control
// bundle, and the forwarding-hit test used by the operand selectors.
package core_pkg;

  localparam logic [5:0] ADD  = 6'h00;
  localparam logic [5:0] SUB  = 6'h01;
  localparam logic [5:0] XOR  = 6'h02;
  localparam logic [5:0] OR   = 6'h03;
  localparam logic [5:0] AND  = 6'h04;
  localparam logic [5:0] LLS  = 6'h05;
  localparam logic [5:0] LRS  = 6'h06;
  localparam logic [5:0] ARS  = 6'h07;
  localparam logic [5:0] SSLT = 6'h08;
  localparam logic [5:0] USLT = 6'h09;

  typedef struct packed {
    logic [5:0] alu_mode;
    logic       use_imm;
    logic       use_pc;
    logic [4:0] rd_addr;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_RESET = '{alu_mode: ADD, use_imm: 1'b0,
                                         use_pc: 1'b0, rd_addr: 5'd0};

  // x0 is hardwired, so a producer targeting it must never be forwarded.
  function automatic logic fwd_hit(input logic       en,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return en && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding selector: the MEM-stage producer wins over WB, and both
// win over the value latched at decode.
module fwd_sel
  import core_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [4:0]          rs_addr,
  input  logic [WordSize-1:0] rs_data,
  input  logic                mem_en,
  input  logic [4:0]          mem_rd,
  input  logic [WordSize-1:0] mem_data,
  input  logic                wb_en,
  input  logic [4:0]          wb_rd,
  input  logic [WordSize-1:0] wb_data,
  output logic [WordSize-1:0] data
);

  // NOTE: default assigned first so every path drives data and no latch is inferred.
  always_comb begin
    data = rs_data;
    if (fwd_hit(mem_en, mem_rd, rs_addr)) begin
      data = mem_data;
    end else if (fwd_hit(wb_en, wb_rd, rs_addr)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with valid/ready handshake, flush, and operand
// forwarding that is refreshed into the stored operands while stalled.
module id_ex_latch
  import core_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [WordSize-1:0] id_pc,
  input  logic [WordSize-1:0] id_rs1_data,
  input  logic [WordSize-1:0] id_rs2_data,
  input  logic [WordSize-1:0] id_imm,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic [4:0]          id_rd_addr,
  input  logic [5:0]          id_alu_mode,
  input  logic                id_use_imm,
  input  logic                id_use_pc,
  input  logic                flush,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [WordSize-1:0] alu_a,
  output logic [WordSize-1:0] alu_b,
  output logic [5:0]          alu_mode,
  output logic [4:0]          ex_rd_addr,
  output logic [WordSize-1:0] ex_store_data,
  input  logic                fwd_mem_en,
  input  logic [4:0]          fwd_mem_rd,
  input  logic [WordSize-1:0] fwd_mem_data,
  input  logic                fwd_wb_en,
  input  logic [4:0]          fwd_wb_rd,
  input  logic [WordSize-1:0] fwd_wb_data
);

  ex_ctrl_t            ctrl_q;
  logic [WordSize-1:0] pc_q;
  logic [WordSize-1:0] imm_q;
  logic [WordSize-1:0] rs1_q;
  logic [WordSize-1:0] rs2_q;
  logic [4:0]          rs1_addr_q;
  logic [4:0]          rs2_addr_q;
  logic [WordSize-1:0] fwd_rs1;
  logic [WordSize-1:0] fwd_rs2;
  logic                capture;
  logic                hold;

  assign id_ready = !ex_valid || ex_ready;
  assign capture  = id_valid && id_ready;
  assign hold     = ex_valid && !ex_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid <= 1'b1;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // While stalled, forwarded operands are written back so they survive after
  // the producing instruction leaves MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= EX_CTRL_RESET;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
    end else if (capture) begin
      ctrl_q     <= '{alu_mode: id_alu_mode, use_imm: id_use_imm,
                      use_pc: id_use_pc, rd_addr: id_rd_addr};
      pc_q       <= id_pc;
      imm_q      <= id_imm;
      rs1_q      <= id_rs1_data;
      rs2_q      <= id_rs2_data;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
    end else if (hold) begin
      rs1_q <= fwd_rs1;
      rs2_q <= fwd_rs2;
    end
  end

  fwd_sel #(.WordSize(WordSize)) u_fwd_rs1 (
    .rs_addr  (rs1_addr_q),
    .rs_data  (rs1_q),
    .mem_en   (fwd_mem_en),
    .mem_rd   (fwd_mem_rd),
    .mem_data (fwd_mem_data),
    .wb_en    (fwd_wb_en),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .data     (fwd_rs1)
  );

  fwd_sel #(.WordSize(WordSize)) u_fwd_rs2 (
    .rs_addr  (rs2_addr_q),
    .rs_data  (rs2_q),
    .mem_en   (fwd_mem_en),
    .mem_rd   (fwd_mem_rd),
    .mem_data (fwd_mem_data),
    .wb_en    (fwd_wb_en),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .data     (fwd_rs2)
  );

  assign alu_a         = ctrl_q.use_pc  ? pc_q  : fwd_rs1;
  assign alu_b         = ctrl_q.use_imm ? imm_q : fwd_rs2;
  assign alu_mode      = ctrl_q.alu_mode;
  assign ex_rd_addr    = ctrl_q.rd_addr;
  assign ex_store_data = fwd_rs2;

endmodule
